eth_frame_loopback: RTL and testbench
=====================================

Name: eth_frame_loopback

Overview:
- Store-and-forward Ethernet frame reflector on the 8-bit AXI-Stream side of the 1G RGMII MAC.
- Acts as AXIS slave to the MAC RX stream and AXIS master to the MAC TX stream.
- Each good received frame is retransmitted with destination and source MAC fields swapped.
- Used for board bring-up and link loopback tests; sits between MAC RX/TX FIFOs, clocked by the 125 MHz MAC logic clock.

Parameters:
- BUF_DEPTH, 2048, frame buffer size in bytes; power of 2, at least 64; frames longer than this are dropped.
- LOCAL_MAC, 48'h02_00_00_00_00_01, station address used only by the optional filter.

Ports:
- clock125  input  1  MAC logic clock, 125 MHz.
- reset  input  1  Reset, synchronous, active-high.
- rx_axis_tdata  input  8  Frame byte from MAC.
- rx_axis_tkeep  input  1  Ignored (always 1).
- rx_axis_tvalid  input  1  RX byte valid.
- rx_axis_tready  output  1  RX byte accept.
- rx_axis_tlast  input  1  Last byte of frame.
- rx_axis_tuser  input  1  Bad-frame flag, sampled with tlast.
- tx_axis_tdata  output  8  Reflected frame byte.
- tx_axis_tkeep  output  1  Constant 1.
- tx_axis_tvalid  output  1  TX byte valid.
- tx_axis_tready  input  1  TX byte accept.
- tx_axis_tlast  output  1  Last byte of frame.
- tx_axis_tuser  output  1  Constant 0.
- frames_looped  output  32  Count of frames retransmitted; wraps at 2^32.
- frames_dropped  output  32  Count of frames discarded; wraps at 2^32.

Behaviour:
- Single clock domain clock125. Reset is synchronous, active-high, and overrides everything.
- Reset values: rx_axis_tready=0, tx_axis_tvalid=0, tx_axis_tlast=0, tx_axis_tdata=0, both counters 0, state RECV, pointers 0.
- State machine states: RECV, SEND.
- RECV:
  - rx_axis_tready=1 from the first cycle after reset deasserts.
  - Each accepted byte (tvalid&tready) is written to buf[wr_ptr]; wr_ptr increments.
  - If a byte arrives with wr_ptr==BUF_DEPTH, set the overflow flag and discard the byte. Keep accepting until tlast.
  - On the accepted tlast byte, compute len = bytes stored including tlast.
  - Drop the frame if rx_axis_tuser=1, the overflow flag is set, or len<14. On drop: frames_dropped+1, wr_ptr=0, flag cleared, stay in RECV.
  - Otherwise latch len, reset wr_ptr, go to SEND.
- SEND:
  - rx_axis_tready=0; no RX bytes are accepted.
  - Output byte index i (0..len-1) is sourced from buf address: i+6 for i<6, i-6 for 6<=i<12, else i. This swaps DA and SA.
  - The buffer is a synchronous-read RAM (one-cycle read) with a prefetch/output register.
  - First tx_axis_tvalid rises 2 cycles after the cycle the tlast byte was accepted.
  - After that, full throughput: 1 byte per cycle while tx_axis_tready=1.
  - tdata and tlast hold stable while tvalid&!tready. tvalid never drops mid-frame.
  - tx_axis_tlast=1 exactly on byte len-1.
  - On the accepted last byte: frames_looped+1, tvalid=0 next cycle, return to RECV. rx_axis_tready=1 on that next cycle.
- Minimum reflected frame is 14 bytes. The MAC pads short frames on TX.
- Reset mid-frame:
  - In RECV, the partial frame is discarded and not counted.
  - In SEND, tx_axis_tvalid falls at that edge with no tlast. The downstream MAC FIFO treats this as an aborted frame.
- rx_axis_tkeep is ignored. The block never stalls RX for more than one frame's send time.
- frames_looped and frames_dropped are never both incremented in one cycle.

Optional Feature:
- Macro: ETH_LOOPBACK_MAC_FILTER_EN.
- Defined: a frame is also dropped (counted in frames_dropped) unless its destination bytes 0..5 equal LOCAL_MAC, byte 0 most significant, or equal FF:FF:FF:FF:FF:FF. The comparison is done incrementally during RECV; no added latency.
- Undefined: no address filtering; LOCAL_MAC is unused.

Test Plan:
- Reset, then 64-byte frame DA=02:00:00:00:00:01, SA=0A:0B:0C:0D:0E:0F, payload 0x00..0x33, with tready=1 -> TX frame of 64 bytes:
  - bytes 0-5 = 0A..0F, bytes 6-11 = 02:00:00:00:00:01, rest unchanged;
  - tlast on byte 63; first tvalid 2 cycles after RX tlast; frames_looped=1.
- Frame with rx_axis_tuser=1 on tlast -> no TX activity, frames_dropped=1. Also a 10-byte frame -> frames_dropped=2.
- Frame of BUF_DEPTH+5 bytes -> all bytes accepted, no TX, frames_dropped+1. Following 60-byte frame reflected correctly.
- Random tx_axis_tready (50%) on a 1500-byte frame -> TX data identical to the no-backpressure run. tdata stable during stalls. rx_axis_tready=0 throughout SEND.
- Reset asserted at TX byte 20 -> next cycle tvalid=0, counters 0, rx_axis_tready=1 one cycle after reset release.
- With ETH_LOOPBACK_MAC_FILTER_EN: DA=02:00:00:00:00:02 -> dropped. Broadcast DA -> reflected.

Source files
------------

// File: rtl/eth_frame_loopback.sv
// eth_frame_loopback: store-and-forward Ethernet frame reflector on the 8-bit
// AXI-Stream side of the MAC. Good frames are buffered, then retransmitted
// with the destination and source MAC fields swapped.
// Optional build macro ETH_LOOPBACK_MAC_FILTER_EN: accept only frames whose
// destination address is LOCAL_MAC or broadcast.
module eth_frame_loopback #(
    parameter int unsigned BUF_DEPTH = 2048,
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01
) (
    input  logic        clock125,
    input  logic        reset,
    input  logic [7:0]  rx_axis_tdata,
    input  logic        rx_axis_tkeep,
    input  logic        rx_axis_tvalid,
    output logic        rx_axis_tready,
    input  logic        rx_axis_tlast,
    input  logic        rx_axis_tuser,
    output logic [7:0]  tx_axis_tdata,
    output logic        tx_axis_tkeep,
    output logic        tx_axis_tvalid,
    input  logic        tx_axis_tready,
    output logic        tx_axis_tlast,
    output logic        tx_axis_tuser,
    output logic [31:0] frames_looped,
    output logic [31:0] frames_dropped
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] DEPTH   = PW'(BUF_DEPTH);
    localparam logic [PW-1:0] MIN_LEN = PW'(14);

    typedef enum logic {RECV, SEND} state_t;

    state_t        state;
    logic [7:0]    mem [BUF_DEPTH];
    logic [7:0]    ram_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] len;
    logic [PW-1:0] rd_idx;
    logic          ovf;
    logic          q_valid;
    logic          q_last;

    logic          rx_accept_c;
    logic          wr_en_c;
    logic          ovf_now_c;
    logic [PW-1:0] len_now_c;
    logic          filter_ok_c;
    logic          drop_c;
    logic          start_c;
    logic          advance_c;
    logic          more_c;
    logic          rd_en_c;
    logic [AW-1:0] rd_addr_c;

    logic          unused_ok;

    assign tx_axis_tkeep = 1'b1;
    assign tx_axis_tuser = 1'b0;
    assign unused_ok     = ^{LOCAL_MAC, rx_axis_tkeep};

    // Output byte i comes from buffer address i+6 / i-6 / i (DA<->SA swap)
    function automatic logic [AW-1:0] swap_addr(input logic [PW-1:0] idx);
        if (idx < PW'(6))
            swap_addr = AW'(idx + PW'(6));
        else if (idx < PW'(12))
            swap_addr = AW'(idx - PW'(6));
        else
            swap_addr = AW'(idx);
    endfunction

`ifdef ETH_LOOPBACK_MAC_FILTER_EN
    logic match_local;
    logic match_bcast;

    function automatic logic [7:0] mac_byte(input logic [2:0] k);
        mac_byte = 8'(LOCAL_MAC >> (8 * (5 - int'(k))));
    endfunction

    assign filter_ok_c = match_local | match_bcast;
`else
    assign filter_ok_c = 1'b1;
`endif

    // Receive-side decisions and read-port control
    always_comb begin
        rx_accept_c = rx_axis_tvalid & rx_axis_tready & (state == RECV);
        wr_en_c     = rx_accept_c & (wr_ptr != DEPTH) & ~reset;
        ovf_now_c   = ovf | (rx_accept_c & (wr_ptr == DEPTH));
        len_now_c   = wr_ptr + PW'(1);
        drop_c      = rx_axis_tuser | ovf_now_c | (len_now_c < MIN_LEN) | ~filter_ok_c;
        start_c     = rx_accept_c & rx_axis_tlast & ~drop_c;
        advance_c   = (state == SEND) & (~tx_axis_tvalid | tx_axis_tready);
        more_c      = rd_idx < len;
        rd_en_c     = (start_c | (advance_c & more_c)) & ~reset;
        rd_addr_c   = swap_addr(start_c ? '0 : rd_idx);
    end

    // Frame buffer: write port from RX, synchronous read port feeding TX
    always_ff @(posedge clock125) begin
        if (wr_en_c)
            mem[wr_ptr[AW-1:0]] <= rx_axis_tdata;
        if (rd_en_c)
            ram_q <= mem[rd_addr_c];
    end

    // Control FSM, counters and registered AXIS outputs
    always_ff @(posedge clock125) begin
        if (reset) begin
            state          <= RECV;
            rx_axis_tready <= 1'b0;
            tx_axis_tvalid <= 1'b0;
            tx_axis_tlast  <= 1'b0;
            tx_axis_tdata  <= '0;
            frames_looped  <= '0;
            frames_dropped <= '0;
            wr_ptr         <= '0;
            len            <= '0;
            rd_idx         <= '0;
            ovf            <= 1'b0;
            q_valid        <= 1'b0;
            q_last         <= 1'b0;
`ifdef ETH_LOOPBACK_MAC_FILTER_EN
            match_local    <= 1'b1;
            match_bcast    <= 1'b1;
`endif
        end else begin
            case (state)
                RECV: begin
                    rx_axis_tready <= 1'b1;
                    tx_axis_tvalid <= 1'b0;
                    tx_axis_tlast  <= 1'b0;
                    if (rx_accept_c) begin
                        if (wr_en_c)
                            wr_ptr <= wr_ptr + PW'(1);
                        else
                            ovf <= 1'b1;
`ifdef ETH_LOOPBACK_MAC_FILTER_EN
                        if (wr_ptr < PW'(6)) begin
                            if (rx_axis_tdata != mac_byte(wr_ptr[2:0]))
                                match_local <= 1'b0;
                            if (rx_axis_tdata != 8'hFF)
                                match_bcast <= 1'b0;
                        end
`endif
                        if (rx_axis_tlast) begin
                            wr_ptr <= '0;
                            ovf    <= 1'b0;
`ifdef ETH_LOOPBACK_MAC_FILTER_EN
                            match_local <= 1'b1;
                            match_bcast <= 1'b1;
`endif
                            if (drop_c) begin
                                frames_dropped <= frames_dropped + 32'd1;
                            end else begin
                                len            <= len_now_c;
                                state          <= SEND;
                                rx_axis_tready <= 1'b0;
                                rd_idx         <= PW'(1);
                                q_valid        <= 1'b1;
                                q_last         <= 1'b0;
                            end
                        end
                    end
                end
                SEND: begin
                    rx_axis_tready <= 1'b0;
                    if (advance_c) begin
                        tx_axis_tvalid <= q_valid;
                        tx_axis_tdata  <= ram_q;
                        tx_axis_tlast  <= q_last;
                        if (more_c) begin
                            q_valid <= 1'b1;
                            q_last  <= (rd_idx == len - PW'(1));
                            rd_idx  <= rd_idx + PW'(1);
                        end else begin
                            q_valid <= 1'b0;
                        end
                    end
                    if (tx_axis_tvalid & tx_axis_tready & tx_axis_tlast) begin
                        frames_looped  <= frames_looped + 32'd1;
                        state          <= RECV;
                        rx_axis_tready <= 1'b1;
                        tx_axis_tvalid <= 1'b0;
                        tx_axis_tlast  <= 1'b0;
                        q_valid        <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_loopback.sv
// Self-checking bench for eth_frame_loopback: randomized frames against a
// queue-based reflection model; honours ETH_LOOPBACK_MAC_FILTER_EN.
module tb_eth_frame_loopback;

    localparam int unsigned BUF_DEPTH = 2048;
    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST     = 48'hFF_FF_FF_FF_FF_FF;

    typedef logic [7:0] byte_q_t [$];

    logic        clock125 = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_tdata = '0;
    logic        rx_tvalid = 1'b0;
    logic        rx_tready;
    logic        rx_tlast = 1'b0;
    logic        rx_tuser = 1'b0;
    logic [7:0]  tx_tdata;
    logic        tx_tkeep;
    logic        tx_tvalid;
    logic        tx_tready = 1'b0;
    logic        tx_tlast;
    logic        tx_tuser;
    logic [31:0] frames_looped;
    logic [31:0] frames_dropped;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rx_last_cyc = 0;
    int exp_looped = 0;
    int exp_dropped = 0;
    logic [7:0] frm [0:4095];
    byte_q_t got;

    eth_frame_loopback #(.BUF_DEPTH(BUF_DEPTH), .LOCAL_MAC(LOCAL_MAC)) dut (
        .clock125(clock125), .reset(reset),
        .rx_axis_tdata(rx_tdata), .rx_axis_tkeep(1'b1), .rx_axis_tvalid(rx_tvalid),
        .rx_axis_tready(rx_tready), .rx_axis_tlast(rx_tlast), .rx_axis_tuser(rx_tuser),
        .tx_axis_tdata(tx_tdata), .tx_axis_tkeep(tx_tkeep), .tx_axis_tvalid(tx_tvalid),
        .tx_axis_tready(tx_tready), .tx_axis_tlast(tx_tlast), .tx_axis_tuser(tx_tuser),
        .frames_looped(frames_looped), .frames_dropped(frames_dropped)
    );

    always #4 clock125 = ~clock125;
    always @(posedge clock125) cyc = cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Reflected frame: SA field, then DA field, then everything from byte 12 on
    task automatic model_reflect(input int len, output byte_q_t q);
        byte_q_t da, sa, rest;
        for (int i = 0; i < 6; i++) da.push_back(frm[i]);
        for (int i = 6; i < 12; i++) sa.push_back(frm[i]);
        for (int i = 12; i < len; i++) rest.push_back(frm[i]);
        q = {sa, da, rest};
    endtask

    function automatic bit model_drop(input int len, input bit bad, input logic [47:0] da);
        bit d;
        d = bad || (len < 14) || (len > BUF_DEPTH);
`ifdef ETH_LOOPBACK_MAC_FILTER_EN
        if (da != LOCAL_MAC && da != BCAST) d = 1'b1;
`else
        if (da == 48'h0) d = d;
`endif
        return d;
    endfunction

    task automatic make_frame(input int len, input logic [47:0] da, input logic [47:0] sa, input bit ramp);
        for (int i = 0; i < len; i++) begin
            if (i < 6)       frm[i] = 8'(da >> (8 * (5 - i)));
            else if (i < 12) frm[i] = 8'(sa >> (8 * (11 - i)));
            else             frm[i] = ramp ? 8'(i - 12) : 8'($urandom);
        end
    endtask

    task automatic send_frame(input int len, input bit bad, input int gap_pct);
        bit acc;
        int t;
        for (int i = 0; i < len; i++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                rx_tvalid = 1'b0;
                @(posedge clock125); #1;
            end
            rx_tvalid = 1'b1;
            rx_tdata  = frm[i];
            rx_tlast  = (i == len - 1);
            rx_tuser  = bad && (i == len - 1);
            t = 0;
            acc = 1'b0;
            while (!acc) begin
                acc = (rx_tready === 1'b1);
                @(posedge clock125); #1;
                t++;
                if (!acc && t > 6000) begin
                    errors++;
                    $display("FAIL rx_accept_timeout: byte %0d not accepted, rx_tready=%b required 1", i, rx_tready);
                    rx_tvalid = 1'b0;
                    return;
                end
            end
        end
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
        rx_tuser  = 1'b0;
        rx_last_cyc = cyc;
    endtask

    // Drives tx_tready and collects bytes, checking AXIS protocol along the way
    task automatic collect_tx(input int exp_len, input int ready_pct, input int abort_at, input bit check_lat);
        bit first = 1'b1;
        bit prev_stall = 1'b0;
        bit rdy, hs;
        logic [7:0] prev_d = '0, d;
        logic prev_l = 1'b0;
        int t = 0;
        got.delete();
        while (got.size() < exp_len) begin
            if (!first) begin
                checks++;
                if (tx_tvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL tvalid_mid_frame: tvalid=%b at byte %0d, required 1", tx_tvalid, got.size());
                end
            end
            if (tx_tvalid === 1'b1) begin
                if (first && check_lat) begin
                    checks++;
                    if (cyc !== rx_last_cyc + 1) begin
                        errors++;
                        $display("FAIL first_tvalid_latency: cycle %0d, required %0d", cyc, rx_last_cyc + 1);
                    end
                end
                first = 1'b0;
                checks++;
                if (rx_tready !== 1'b0) begin
                    errors++;
                    $display("FAIL rx_tready_in_send: rx_tready=%b, required 0", rx_tready);
                end
                checks++;
                if (tx_tlast !== (got.size() == exp_len - 1)) begin
                    errors++;
                    $display("FAIL tlast_position: tlast=%b at byte %0d of %0d", tx_tlast, got.size(), exp_len);
                end
                if (prev_stall) begin
                    checks++;
                    if (tx_tdata !== prev_d || tx_tlast !== prev_l) begin
                        errors++;
                        $display("FAIL stall_stable: data=%h last=%b, required data=%h last=%b",
                                 tx_tdata, tx_tlast, prev_d, prev_l);
                    end
                end
                if (abort_at >= 0 && got.size() == abort_at) return;
            end
            rdy = ($urandom_range(99) < ready_pct);
            tx_tready = rdy;
            hs = (tx_tvalid === 1'b1) && rdy;
            d = tx_tdata;
            prev_stall = (tx_tvalid === 1'b1) && !rdy;
            prev_d = tx_tdata;
            prev_l = tx_tlast;
            @(posedge clock125); #1;
            if (hs) got.push_back(d);
            t++;
            if (t > 20 * exp_len + 100) begin
                errors++;
                $display("FAIL tx_timeout: got %0d bytes, required %0d", got.size(), exp_len);
                return;
            end
        end
        tx_tready = 1'b1;
    endtask

    task automatic idle_no_tx(input int n);
        bit seen = 1'b0;
        tx_tready = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (tx_tvalid !== 1'b0) seen = 1'b1;
            @(posedge clock125); #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL no_tx_on_drop: tvalid seen high, required 0");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock125);
        #1;
        checks++;
        if ({rx_tready, tx_tvalid, tx_tlast, tx_tdata} !== 11'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b last=%b data=%h, required all 0",
                     rx_tready, tx_tvalid, tx_tlast, tx_tdata);
        end
        checks++;
        if (frames_looped !== 32'd0 || frames_dropped !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: looped=%0d dropped=%0d, required 0", frames_looped, frames_dropped);
        end
        checks++;
        if (tx_tkeep !== 1'b1 || tx_tuser !== 1'b0) begin
            errors++;
            $display("FAIL const_outputs: tkeep=%b tuser=%b, required 1 0", tx_tkeep, tx_tuser);
        end
        reset = 1'b0;
        @(posedge clock125); #1;
        checks++;
        if (rx_tready !== 1'b1) begin
            errors++;
            $display("FAIL rx_tready_after_reset: %b, required 1", rx_tready);
        end
    endtask

    task automatic test_basic_loop();
        byte_q_t exp;
        make_frame(64, LOCAL_MAC, 48'h0A_0B_0C_0D_0E_0F, 1'b1);
        model_reflect(64, exp);
        send_frame(64, 1'b0, 0);
        collect_tx(64, 100, -1, 1'b1);
        exp_looped++;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL basic_data: got %0d bytes first=%h, required %0d bytes first=%h",
                     got.size(), (got.size() > 0) ? got[0] : 8'h00, exp.size(), exp[0]);
        end
        checks++;
        if (got.size() != 64 || got[0] !== 8'h0A || got[5] !== 8'h0F || got[6] !== 8'h02 ||
            got[11] !== 8'h01 || got[12] !== 8'h00 || got[63] !== 8'h33) begin
            errors++;
            $display("FAIL basic_fields: size=%0d, required 64 with SA/DA swapped and payload ramp", got.size());
        end
        checks++;
        if (tx_tvalid !== 1'b0 || rx_tready !== 1'b1) begin
            errors++;
            $display("FAIL basic_end: tvalid=%b rx_tready=%b, required 0 1", tx_tvalid, rx_tready);
        end
        checks++;
        if (frames_looped !== 32'(exp_looped)) begin
            errors++;
            $display("FAIL basic_looped: %0d, required %0d", frames_looped, exp_looped);
        end
    endtask

    task automatic test_drop();
        make_frame(64, LOCAL_MAC, 48'h0A_0B_0C_0D_0E_0F, 1'b0);
        send_frame(64, 1'b1, 0);
        exp_dropped++;
        idle_no_tx(10);
        checks++;
        if (frames_dropped !== 32'(exp_dropped)) begin
            errors++;
            $display("FAIL drop_tuser: dropped=%0d, required %0d", frames_dropped, exp_dropped);
        end
        make_frame(10, LOCAL_MAC, 48'h0A_0B_0C_0D_0E_0F, 1'b0);
        send_frame(10, 1'b0, 0);
        exp_dropped++;
        idle_no_tx(10);
        checks++;
        if (frames_dropped !== 32'(exp_dropped) || frames_looped !== 32'(exp_looped)) begin
            errors++;
            $display("FAIL drop_short: dropped=%0d looped=%0d, required %0d %0d",
                     frames_dropped, frames_looped, exp_dropped, exp_looped);
        end
    endtask

    task automatic test_overflow();
        byte_q_t exp;
        make_frame(BUF_DEPTH + 5, LOCAL_MAC, 48'h11_22_33_44_55_66, 1'b0);
        send_frame(BUF_DEPTH + 5, 1'b0, 5);
        exp_dropped++;
        idle_no_tx(10);
        checks++;
        if (frames_dropped !== 32'(exp_dropped)) begin
            errors++;
            $display("FAIL overflow_drop: dropped=%0d, required %0d", frames_dropped, exp_dropped);
        end
        make_frame(60, LOCAL_MAC, 48'hA1_A2_A3_A4_A5_A6, 1'b0);
        model_reflect(60, exp);
        send_frame(60, 1'b0, 0);
        collect_tx(60, 100, -1, 1'b1);
        exp_looped++;
        checks++;
        if (got !== exp || frames_looped !== 32'(exp_looped)) begin
            errors++;
            $display("FAIL after_overflow: got %0d bytes looped=%0d, required %0d bytes looped=%0d",
                     got.size(), frames_looped, exp.size(), exp_looped);
        end
    endtask

    task automatic test_backpressure();
        byte_q_t exp, ref_run;
        make_frame(1500, LOCAL_MAC, 48'h0C_0D_0E_0F_10_11, 1'b0);
        model_reflect(1500, exp);
        send_frame(1500, 1'b0, 0);
        collect_tx(1500, 100, -1, 1'b1);
        exp_looped++;
        ref_run = got;
        send_frame(1500, 1'b0, 10);
        collect_tx(1500, 50, -1, 1'b1);
        exp_looped++;
        checks++;
        if (got !== ref_run) begin
            errors++;
            $display("FAIL backpressure_vs_free: got %0d bytes, required %0d identical bytes", got.size(), ref_run.size());
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL backpressure_vs_model: got %0d bytes, required %0d model bytes", got.size(), exp.size());
        end
        checks++;
        if (frames_looped !== 32'(exp_looped)) begin
            errors++;
            $display("FAIL backpressure_looped: %0d, required %0d", frames_looped, exp_looped);
        end
    endtask

    task automatic test_reset_mid_send();
        make_frame(64, LOCAL_MAC, 48'h0A_0B_0C_0D_0E_0F, 1'b0);
        send_frame(64, 1'b0, 0);
        collect_tx(64, 100, 20, 1'b0);
        reset = 1'b1;
        @(posedge clock125); #1;
        exp_looped = 0;
        exp_dropped = 0;
        checks++;
        if (tx_tvalid !== 1'b0 || tx_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_send_tvalid: tvalid=%b tlast=%b, required 0 0", tx_tvalid, tx_tlast);
        end
        checks++;
        if (frames_looped !== 32'd0 || frames_dropped !== 32'd0 || rx_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_send_state: looped=%0d dropped=%0d rx_tready=%b, required 0 0 0",
                     frames_looped, frames_dropped, rx_tready);
        end
        reset = 1'b0;
        @(posedge clock125); #1;
        checks++;
        if (rx_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_send_release: rx_tready=%b, required 1", rx_tready);
        end
    endtask

    task automatic test_random_frames();
        byte_q_t exp;
        int len, sel;
        bit bad, drop;
        logic [47:0] da;
        for (int n = 0; n < 12; n++) begin
            len = $urandom_range(200, 1);
            bad = ($urandom_range(9) == 0);
            sel = $urandom_range(2);
            da  = (sel == 0) ? LOCAL_MAC : (sel == 1) ? BCAST : {16'h1234, 32'($urandom)};
            make_frame(len, da, {16'h0A0B, 32'($urandom)}, 1'b0);
            drop = model_drop(len, bad, da);
            send_frame(len, bad, $urandom_range(20));
            if (drop) begin
                exp_dropped++;
                idle_no_tx(6);
            end else begin
                model_reflect(len, exp);
                collect_tx(len, $urandom_range(100, 30), -1, 1'b1);
                exp_looped++;
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL random_frame_%0d: got %0d bytes, required %0d", n, got.size(), exp.size());
                end
            end
            checks++;
            if (frames_looped !== 32'(exp_looped) || frames_dropped !== 32'(exp_dropped)) begin
                errors++;
                $display("FAIL random_counters_%0d: looped=%0d dropped=%0d, required %0d %0d",
                         n, frames_looped, frames_dropped, exp_looped, exp_dropped);
            end
        end
    endtask

`ifdef ETH_LOOPBACK_MAC_FILTER_EN
    task automatic test_mac_filter();
        byte_q_t exp;
        make_frame(64, 48'h02_00_00_00_00_02, 48'h0A_0B_0C_0D_0E_0F, 1'b0);
        send_frame(64, 1'b0, 0);
        exp_dropped++;
        idle_no_tx(10);
        checks++;
        if (frames_dropped !== 32'(exp_dropped)) begin
            errors++;
            $display("FAIL filter_foreign_da: dropped=%0d, required %0d", frames_dropped, exp_dropped);
        end
        make_frame(64, BCAST, 48'h0A_0B_0C_0D_0E_0F, 1'b0);
        model_reflect(64, exp);
        send_frame(64, 1'b0, 0);
        collect_tx(64, 100, -1, 1'b1);
        exp_looped++;
        checks++;
        if (got !== exp || frames_looped !== 32'(exp_looped)) begin
            errors++;
            $display("FAIL filter_broadcast: got %0d bytes looped=%0d, required %0d looped=%0d",
                     got.size(), frames_looped, exp.size(), exp_looped);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_loop();
        test_drop();
        test_overflow();
        test_backpressure();
        test_reset_mid_send();
        test_random_frames();
`ifdef ETH_LOOPBACK_MAC_FILTER_EN
        test_mac_filter();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
